// File: rtl/svc_rv_ext_fp_issue_pkg.sv
// Shared RV FP definitions: opcode/funct7/rounding constants, issue FSM states,
// and the integer-destination decode helper.
package svc_rv_ext_fp_issue_pkg;

  localparam logic [6:0] OP_FP       = 7'b1010011;

  localparam logic [6:0] FP7_FADD    = 7'b0000000;
  localparam logic [6:0] FP7_FSUB    = 7'b0000100;
  localparam logic [6:0] FP7_FMUL    = 7'b0001000;
  localparam logic [6:0] FP7_FDIV    = 7'b0001100;
  localparam logic [6:0] FP7_FSQRT   = 7'b0101100;
  localparam logic [6:0] FP7_FCMP    = 7'b1010000;
  localparam logic [6:0] FP7_FCVTWS  = 7'b1100000;
  localparam logic [6:0] FP7_FMVXW   = 7'b1110000;

  localparam logic [2:0] FRM_RNE     = 3'b000;
  localparam logic [2:0] FRM_RTZ     = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WB
  } fp_issue_state_t;

  // FMV.X.W / FCLASS, compares and FCVT.W[U].S land in the integer regfile.
  function automatic logic fp_writes_int(input logic [31:0] instr);
    logic [6:0] f7;
    f7 = instr[31:25];
    return (instr[6:0] == OP_FP) &&
           ((f7 == FP7_FMVXW) || (f7 == FP7_FCMP) || (f7 == FP7_FCVTWS));
  endfunction

endpackage

// File: rtl/svc_rv_ext_fp_issue.sv
// Issue controller for the FP execute unit: holds one op on the EX interface
// until its result returns, then strobes a single writeback. Owns frm/fflags.
module svc_rv_ext_fp_issue
  import svc_rv_ext_fp_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TW             = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_fp_rs1,
  input  logic [31:0] in_fp_rs2,
  input  logic [31:0] in_fp_rs3,
  input  logic [31:0] in_rs1,
  input  logic        flush,
  output logic        op_valid,
  output logic [31:0] instr,
  output logic [31:0] fp_rs1,
  output logic [31:0] fp_rs2,
  output logic [31:0] fp_rs3,
  output logic [31:0] rs1,
  output logic [2:0]  frm_csr,
  input  logic        result_valid,
  input  logic [31:0] result,
  input  logic [4:0]  fflags,
  input  logic        busy,
  output logic        wb_valid,
  output logic        wb_fp,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        frm_wr_en,
  input  logic [2:0]  frm_wr_data,
  input  logic        fflags_wr_en,
  input  logic [4:0]  fflags_wr_data,
  output logic [4:0]  fflags_acc,
  output logic        timeout_err
);

  fp_issue_state_t state;
  logic [TW-1:0]   tmo_cnt;
  logic            accept;
  logic            capture;
  logic [4:0]      flags_base;

  assign in_ready   = ((state == ST_IDLE) || (state == ST_WB)) && !busy && !flush;
  assign accept     = in_valid && in_ready;
  assign capture    = (state == ST_ISSUE) && !flush && result_valid;
  // A CSR write lands before the captured flags are OR-ed in.
  assign flags_base = fflags_wr_en ? fflags_wr_data : fflags_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_valid    <= 1'b0;
      wb_valid    <= 1'b0;
      timeout_err <= 1'b0;
      instr       <= '0;
      fp_rs1      <= '0;
      fp_rs2      <= '0;
      fp_rs3      <= '0;
      rs1         <= '0;
      wb_fp       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      frm_csr     <= FRM_RNE;
      fflags_acc  <= '0;
      tmo_cnt     <= '0;
    end else begin
      wb_valid    <= 1'b0;
      timeout_err <= 1'b0;
      fflags_acc  <= capture ? (flags_base | fflags) : flags_base;
      if (frm_wr_en) begin
        frm_csr <= frm_wr_data;
      end

      if (accept) begin
        instr    <= in_instr;
        fp_rs1   <= in_fp_rs1;
        fp_rs2   <= in_fp_rs2;
        fp_rs3   <= in_fp_rs3;
        rs1      <= in_rs1;
        wb_fp    <= !fp_writes_int(in_instr);
        wb_rd    <= in_instr[11:7];
        op_valid <= 1'b1;
        tmo_cnt  <= '0;
        state    <= ST_ISSUE;
      end else begin
        case (state)
          ST_ISSUE: begin
            // Flush wins over a result arriving in the same cycle.
            if (flush) begin
              op_valid <= 1'b0;
              state    <= ST_IDLE;
            end else if (result_valid) begin
              op_valid <= 1'b0;
              wb_valid <= 1'b1;
              wb_data  <= result;
              state    <= ST_WB;
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              op_valid    <= 1'b0;
              timeout_err <= 1'b1;
              tmo_cnt     <= tmo_cnt + 1'b1;
              state       <= ST_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
